dbg_guv_log_arb: RTL and testbench

- Round-robin arbiter that merges the concatenated log streams of N dbg_guv instances onto one log output stream for a single host-side sink.
- Arbitrates on packet boundaries: a granted input keeps the output until its TLAST flit is transferred.
- Tags each output flit with the source index on TDEST.
- Output is fully registered through a 2-entry skid buffer; no combinational path from out_TREADY to any in_TREADY.

---
 rtl/dbg_guv_log_arb_pkg.sv | 14 +
 rtl/dbg_guv_log_arb_skid2.sv | 47 ++++
 rtl/dbg_guv_log_arb.sv | 113 +++++++++++
 tb/tb_dbg_guv_log_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_guv_log_arb_pkg.sv
// Shared types and width helpers for the dbg_guv log-stream arbiter.
package dbg_guv_log_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Log flit carries the data word plus one strobe bit per data byte.
   function automatic int log_width(input int dw);
      return dw + dw / 8;
   endfunction

endpackage

// File: rtl/dbg_guv_log_arb_skid2.sv
// Generic 2-entry registered skid buffer; ready and all outputs come straight from flops.
module dbg_guv_log_arb_skid2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       count, count_nxt;
   logic             push, pop;

   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b1;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count    <= count_nxt;
         // Ready for the next cycle is decided from post-edge occupancy.
         in_ready <= (count_nxt != 2'd2);
      end
   end

endmodule

// File: rtl/dbg_guv_log_arb.sv
// Packet-granular round-robin merge of N log streams onto one TDEST-tagged output.
module dbg_guv_log_arb
   import dbg_guv_log_arb_pkg::*;
#(
   parameter int N_INPUTS   = 4,
   parameter int DATA_WIDTH = 64,
   parameter int SEL_WIDTH  = 2,
   parameter int CNT_SIZE   = 16,
   localparam int LW        = log_width(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_INPUTS*LW-1:0] in_TDATA,
   input  logic [N_INPUTS-1:0]    in_TVALID,
   output logic [N_INPUTS-1:0]    in_TREADY,
   input  logic [N_INPUTS-1:0]    in_TLAST,
   output logic [LW-1:0]          out_TDATA,
   output logic                   out_TVALID,
   input  logic                   out_TREADY,
   output logic                   out_TLAST,
   output logic [SEL_WIDTH-1:0]   out_TDEST,
   output logic                   busy,
   output logic [CNT_SIZE-1:0]    pkt_cnt
);

   localparam int SW = LW + 1 + SEL_WIDTH;

   arb_state_t           state, state_nxt;
   logic [SEL_WIDTH-1:0] ptr, grant, pick, cand;
   logic                 any_vld;
   int                   scan_idx;
   logic [LW-1:0]        in_data [N_INPUTS];
   logic                 skid_ready, push, last_xfer;
   logic [SW-1:0]        skid_out;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_slice
      assign in_data[g] = in_TDATA[g*LW +: LW];
   end

   // Scan downward so the lowest offset from ptr is the one left in pick.
   always_comb begin
      any_vld  = 1'b0;
      pick     = '0;
      scan_idx = 0;
      cand     = '0;
      for (int k = N_INPUTS - 1; k >= 0; k--) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= N_INPUTS)
            scan_idx = scan_idx - N_INPUTS;
         cand = SEL_WIDTH'(scan_idx);
         if (in_TVALID[cand]) begin
            any_vld = 1'b1;
            pick    = cand;
         end
      end
   end

   assign push      = (state == LOCKED) & in_TVALID[grant] & skid_ready;
   assign last_xfer = push & in_TLAST[grant];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         grant <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_vld)
            grant <= pick;
         if (last_xfer)
            ptr <= (grant == SEL_WIDTH'(N_INPUTS - 1)) ? '0 : grant + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_vld)   state_nxt = LOCKED;
         LOCKED:  if (last_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_TREADY = '0;
      if (state == LOCKED)
         in_TREADY[grant] = skid_ready;
   end

   dbg_guv_log_arb_skid2 #(.WIDTH(SW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({in_data[grant], in_TLAST[grant], grant}),
      .in_valid  (push),
      .in_ready  (skid_ready),
      .out_data  (skid_out),
      .out_valid (out_TVALID),
      .out_ready (out_TREADY)
   );

   assign out_TDATA = skid_out[SW-1 -: LW];
   assign out_TLAST = skid_out[SEL_WIDTH];
   assign out_TDEST = skid_out[SEL_WIDTH-1:0];
   assign busy      = (state == LOCKED) | out_TVALID;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pkt_cnt <= '0;
      else if (out_TVALID && out_TREADY && out_TLAST)
         pkt_cnt <= pkt_cnt + 1'b1;
   end

endmodule

// File: tb/tb_dbg_guv_log_arb.sv
// Randomised and directed bench for dbg_guv_log_arb against a queue-level reference model.
module tb_dbg_guv_log_arb;

   localparam int NI  = 4;
   localparam int DW  = 64;
   localparam int LW  = DW + DW / 8;
   localparam int SEL = 2;
   localparam int CNT = 4;

   typedef struct {
      logic [LW-1:0] data;
      logic          last;
   } flit_t;

   typedef struct {
      logic [LW-1:0]  data;
      logic           last;
      logic [SEL-1:0] dest;
   } ent_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NI*LW-1:0]    in_TDATA = '0;
   logic [NI-1:0]       in_TVALID = '0;
   logic [NI-1:0]       in_TREADY;
   logic [NI-1:0]       in_TLAST = '0;
   logic [LW-1:0]       out_TDATA;
   logic                out_TVALID;
   logic                out_TREADY = 1'b0;
   logic                out_TLAST;
   logic [SEL-1:0]      out_TDEST;
   logic                busy;
   logic [CNT-1:0]      pkt_cnt;

   int checks = 0;
   int failures = 0;

   dbg_guv_log_arb #(
      .N_INPUTS(NI), .DATA_WIDTH(DW), .SEL_WIDTH(SEL), .CNT_SIZE(CNT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TLAST(in_TLAST),
      .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
      .out_TLAST(out_TLAST), .out_TDEST(out_TDEST), .busy(busy), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- stimulus driver ----------------
   flit_t       q_in [NI][$];
   logic [NI-1:0] held = '0;
   logic [NI-1:0] pend = '0;
   int          vprob = 100;
   int          rmode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
   logic        rtog = 1'b0;

   always begin
      @(posedge clk);
      #2;
      if (!rst) begin
         held = '0;
         pend = '0;
      end else begin
         for (int i = 0; i < NI; i++)
            if (pend[i]) begin
               void'(q_in[i].pop_front());
               held[i] = 1'b0;
            end
         pend = '0;
         for (int i = 0; i < NI; i++)
            if (!held[i] && q_in[i].size() > 0 && $urandom_range(99) < vprob)
               held[i] = 1'b1;
      end
      for (int i = 0; i < NI; i++) begin
         in_TVALID[i]           = held[i];
         in_TLAST[i]            = held[i] ? q_in[i][0].last : 1'b0;
         in_TDATA[i*LW +: LW]   = held[i] ? q_in[i][0].data : '0;
      end
      rtog = ~rtog;
      case (rmode)
         0:       out_TREADY = 1'b1;
         1:       out_TREADY = rtog;
         2:       out_TREADY = ($urandom_range(99) < 60);
         default: out_TREADY = 1'b0;
      endcase
   end

   // ---------------- reference model ----------------
   // Output side is a plain FIFO of at most two entries; arbitration follows the
   // rotating-priority rule at packet starts.
   ent_t mq[$];
   bit   m_locked;
   int   m_ptr, m_grant, m_cnt;
   bit   m_rdy;

   always @(posedge clk or negedge rst) begin
      bit   pop, push;
      ent_t e;
      int   idx;
      if (!rst) begin
         m_locked = 0; m_ptr = 0; m_grant = 0; m_cnt = 0; m_rdy = 1;
         mq.delete();
      end else begin
         pop  = (mq.size() > 0) && out_TREADY;
         push = m_locked && m_rdy && in_TVALID[m_grant];
         e    = '{in_TDATA[m_grant*LW +: LW], in_TLAST[m_grant], SEL'(m_grant)};
         if (pop) begin
            if (mq[0].last) m_cnt = (m_cnt + 1) % (1 << CNT);
            void'(mq.pop_front());
         end
         if (push) begin
            mq.push_back(e);
            if (e.last) begin
               m_locked = 0;
               m_ptr    = (m_grant + 1) % NI;
            end
         end else if (!m_locked) begin
            for (int k = 0; k < NI; k++) begin
               idx = (m_ptr + k) % NI;
               if (!m_locked && in_TVALID[idx]) begin
                  m_grant  = idx;
                  m_locked = 1;
               end
            end
         end
         m_rdy = (mq.size() < 2);
      end
   end

   // ---------------- monitor / compare ----------------
   ent_t log_q[$];

   always @(negedge clk) begin
      logic [NI-1:0] exp_rdy;
      if (rst) begin
         for (int i = 0; i < NI; i++)
            pend[i] = in_TVALID[i] & in_TREADY[i];
         if (out_TVALID && out_TREADY)
            log_q.push_back('{out_TDATA, out_TLAST, out_TDEST});
         exp_rdy = '0;
         if (m_locked && m_rdy) exp_rdy[m_grant] = 1'b1;
         chk("in_TREADY", 128'(in_TREADY), 128'(exp_rdy));
         chk("out_TVALID", 128'(out_TVALID), 128'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("out_TDATA", 128'(out_TDATA), 128'(mq[0].data));
            chk("out_TLAST", 128'(out_TLAST), 128'(mq[0].last));
            chk("out_TDEST", 128'(out_TDEST), 128'(mq[0].dest));
         end
         chk("busy", 128'(busy), 128'(m_locked || mq.size() > 0));
         chk("pkt_cnt", 128'(pkt_cnt), 128'(m_cnt));
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [LW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic add_pkt(input int src, input int len, input logic [LW-1:0] base);
      for (int j = 0; j < len; j++)
         q_in[src].push_back('{base + LW'(j), (j == len - 1)});
   endtask

   function automatic bit pending();
      bit b;
      b = (mq.size() != 0) || m_locked;
      for (int i = 0; i < NI; i++)
         if (q_in[i].size() != 0) b = 1;
      return b;
   endfunction

   task automatic wait_idle(input string nm, input int budget);
      int c;
      c = 0;
      while (pending() && c < budget) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (c >= budget) begin
         failures++;
         $display("FAIL %s_timeout actual=%0d cycles expected<%0d", nm, c, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_in_TREADY"}, 128'(in_TREADY), 128'(0));
      chk({nm, "_out_TVALID"}, 128'(out_TVALID), 128'(0));
      chk({nm, "_out_TDATA"}, 128'(out_TDATA), 128'(0));
      chk({nm, "_out_TLAST"}, 128'(out_TLAST), 128'(0));
      chk({nm, "_out_TDEST"}, 128'(out_TDEST), 128'(0));
      chk({nm, "_busy"}, 128'(busy), 128'(0));
      chk({nm, "_pkt_cnt"}, 128'(pkt_cnt), 128'(0));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int            exp2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int            exp4 [3]  = '{2, 3, 1};
      logic [LW-1:0] a;
      logic [LW-1:0] exp3 [24];
      int            total, len, src;

      #2 rst = 1'b0;
      #1 chk_zero_outputs("reset");
      @(posedge clk); #4 rst = 1'b1;

      // All four inputs backlogged with 2-flit packets.
      log_q.delete();
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < NI; i++) add_pkt(i, 2, rnd_word());
      wait_idle("rr4", 400);
      chk("rr4_count", 128'(log_q.size()), 128'(24));
      for (int k = 0; k < 10; k++)
         if (k < log_q.size()) chk("rr4_dest", 128'(log_q[k].dest), 128'(exp2[k]));

      // Single 3-flit packet on input 0.
      log_q.delete();
      a = rnd_word();
      add_pkt(0, 3, a);
      wait_idle("pkt3", 200);
      chk("pkt3_count", 128'(log_q.size()), 128'(3));
      for (int j = 0; j < 3; j++)
         if (j < log_q.size()) begin
            chk("pkt3_data", 128'(log_q[j].data), 128'(a + LW'(j)));
            chk("pkt3_dest", 128'(log_q[j].dest), 128'(0));
            chk("pkt3_last", 128'(log_q[j].last), 128'(j == 2));
         end
      chk("pkt3_pkt_cnt", 128'(pkt_cnt), 128'(13));

      // Wrap of the scan: after input 2, only input 1 requests.
      add_pkt(2, 1, rnd_word());
      wait_idle("wrap_a", 200);
      log_q.delete();
      add_pkt(1, 2, rnd_word());
      wait_idle("wrap_b", 200);
      chk("wrap_dest", 128'(log_q.size() > 0 ? log_q[0].dest : 2'd3), 128'(1));
      log_q.delete();
      add_pkt(1, 1, rnd_word()); add_pkt(2, 1, rnd_word()); add_pkt(3, 1, rnd_word());
      wait_idle("wrap_c", 200);
      for (int k = 0; k < 3; k++)
         if (k < log_q.size()) chk("wrap_order", 128'(log_q[k].dest), 128'(exp4[k]));

      // 8-flit packets on input 1 under a toggling sink.
      rmode = 1;
      log_q.delete();
      for (int p = 0; p < 3; p++) begin
         a = rnd_word();
         add_pkt(1, 8, a);
         for (int j = 0; j < 8; j++) exp3[p*8 + j] = a + LW'(j);
      end
      wait_idle("toggle", 600);
      chk("toggle_count", 128'(log_q.size()), 128'(24));
      for (int k = 0; k < 24; k++)
         if (k < log_q.size()) chk("toggle_data", 128'(log_q[k].data), 128'(exp3[k]));

      // Random traffic, gaps and back-pressure.
      rmode = 2; vprob = 50; total = 0;
      log_q.delete();
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 5);
         src = $urandom_range(0, NI - 1);
         add_pkt(src, len, rnd_word());
         total += len;
      end
      wait_idle("random", 8000);
      chk("random_count", 128'(log_q.size()), 128'(total));

      // Asynchronous reset with a packet in flight and the skid full.
      rmode = 3; vprob = 100;
      add_pkt(2, 8, rnd_word());
      repeat (5) @(negedge clk);
      chk("rst_pre_valid", 128'(out_TVALID), 128'(1));
      #2 rst = 1'b0;
      for (int i = 0; i < NI; i++) q_in[i].delete();
      #1 chk_zero_outputs("async_rst");
      repeat (2) @(posedge clk);
      #4 rst = 1'b1;
      rmode = 0;
      log_q.delete();
      add_pkt(0, 2, rnd_word()); add_pkt(2, 2, rnd_word());
      wait_idle("post_rst", 200);
      chk("post_rst_first", 128'(log_q.size() > 0 ? log_q[0].dest : 2'd3), 128'(0));
      chk("post_rst_second", 128'(log_q.size() > 2 ? log_q[2].dest : 2'd3), 128'(2));

      // Counter wrap: 17 single-flit packets from a fresh reset.
      @(posedge clk); #4 rst = 1'b0;
      @(posedge clk); #4 rst = 1'b1;
      for (int p = 0; p < 17; p++) add_pkt($urandom_range(0, NI - 1), 1, rnd_word());
      wait_idle("wrapcnt", 400);
      chk("pkt_cnt_wrap", 128'(pkt_cnt), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
